// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned N_REQ_DEF       = 3;
  localparam int unsigned ACK_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } sched_state_t;

  // Byte captured from the granted requester, with its end-of-frame marker.
  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } tx_byte_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: one-hot grant to the first requester after ptr, wrapping.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N     = N_REQ_DEF,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt_c
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_c = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = PTR_W'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt_c[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler multiplexing N_REQ byte streams onto one UART transmitter.
// Frames are granted whole; each byte is handed over with an EN/busy level handshake.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = N_REQ_DEF,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                    CLK_SYS,
  input  logic                    CLK_RST,
  input  logic [N_REQ-1:0]        Req_valid,
  input  logic [BYTE_W*N_REQ-1:0] Req_data,
  input  logic [N_REQ-1:0]        Req_last,
  output logic [N_REQ-1:0]        Req_ready,
  input  logic                    Uart_TX_busy,
  output logic                    Uart_TX_EN,
  output logic [BYTE_W-1:0]       Uart_din,
  output logic [N_REQ-1:0]        Grant,
  output logic                    Sched_busy,
  output logic                    Ack_err
);

  localparam int unsigned      PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned      CNT_W     = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT);
  localparam logic [PTR_W-1:0] PTR_RST   = PTR_W'(N_REQ - 1);

  sched_state_t     state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  tx_byte_t         tx_q, tx_d, sel;
  logic             tx_en_q, tx_en_d;
  logic             sbusy_q, sbusy_d;
  logic             err_q, err_d;
  logic [N_REQ-1:0] arb_gnt_c;
  logic [PTR_W-1:0] arb_idx;
  logic             xfer;

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req   (Req_valid),
    .ptr   (ptr_q),
    .gnt_c (arb_gnt_c)
  );

  always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
    if (!CLK_RST) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ready_q <= '0;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      tx_q    <= '0;
      tx_en_q <= 1'b0;
      sbusy_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      tx_en_q <= tx_en_d;
      sbusy_q <= sbusy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    tx_d    = tx_q;
    tx_en_d = tx_en_q;
    cnt_d   = '0;
    err_d   = 1'b0;
    sel     = '0;
    arb_idx = '0;
    cnt_inc = cnt_q + CNT_W'(1);
    xfer    = |(Req_valid & ready_q);

    // Byte and marker offered by the current owner.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        sel.data = Req_data[i*BYTE_W +: BYTE_W];
        sel.last = Req_last[i];
      end
      if (arb_gnt_c[i]) arb_idx = PTR_W'(i);
    end

    case (state_q)
      ST_IDLE: begin
        if (|Req_valid) begin
          grant_d = arb_gnt_c;
          ptr_d   = arb_idx;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          tx_d    = sel;
          tx_en_d = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (Uart_TX_busy) begin
          tx_en_d = 1'b0;
          state_d = ST_WAIT_DONE;
        end else if (cnt_inc == CNT_LIMIT) begin
          // Transmitter never acknowledged: abandon the rest of the frame.
          err_d   = 1'b1;
          tx_en_d = 1'b0;
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WAIT_DONE: begin
        if (!Uart_TX_busy) begin
          if (tx_q.last) begin
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_LOAD) ? (Req_valid & grant_d) : '0;
    sbusy_d = (state_d != ST_IDLE);
  end

  assign Req_ready  = ready_q;
  assign Uart_TX_EN = tx_en_q;
  assign Uart_din   = tx_q.data;
  assign Grant      = grant_q;
  assign Sched_busy = sbusy_q;
  assign Ack_err    = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: requester queues and a transmitter model on the falling edge.
module tb_uart_tx_sched;

  logic        CLK_SYS;
  logic        CLK_RST;
  logic [2:0]  Req_valid;
  logic [23:0] Req_data;
  logic [2:0]  Req_last;
  logic [2:0]  Req_ready;
  logic        Uart_TX_busy;
  logic        Uart_TX_EN;
  logic [7:0]  Uart_din;
  logic [2:0]  Grant;
  logic        Sched_busy;
  logic        Ack_err;

  int total = 0;
  int bad   = 0;

  // requester byte queues {last, data}
  logic [8:0] mem [3][16];
  int         wr [3];
  int         rd [3];
  logic [2:0] pend;

  // transmitter model and monitor state
  int         busy_len   = 3;
  bit         never_busy = 0;
  int         dly        = 0;
  int         bcnt       = 0;
  bit         en_prev    = 0;
  int         cyc        = 0;
  int         low_run    = 0;
  int         gap_viol   = 0;
  int         n_rise     = 0;
  int         n_err      = 0;
  int         rise_cyc   = 0;
  int         err_cyc    = 0;
  logic [7:0] log_din [32];
  logic [2:0] log_gnt [32];

  uart_tx_sched dut (
    .CLK_SYS      (CLK_SYS),
    .CLK_RST      (CLK_RST),
    .Req_valid    (Req_valid),
    .Req_data     (Req_data),
    .Req_last     (Req_last),
    .Req_ready    (Req_ready),
    .Uart_TX_busy (Uart_TX_busy),
    .Uart_TX_EN   (Uart_TX_EN),
    .Uart_din     (Uart_din),
    .Grant        (Grant),
    .Sched_busy   (Sched_busy),
    .Ack_err      (Ack_err)
  );

  initial begin
    CLK_SYS = 1'b0;
    forever #5 CLK_SYS = ~CLK_SYS;
  end

  // Falling-edge model: transmitter busy response, EN/Ack_err monitor, requesters.
  initial begin
    Req_valid = '0; Req_data = '0; Req_last = '0; Uart_TX_busy = 1'b0; pend = '0;
    for (int i = 0; i < 3; i++) begin wr[i] = 0; rd[i] = 0; end
    forever begin
      @(negedge CLK_SYS);
      cyc++;
      if (!CLK_RST) begin
        Uart_TX_busy = 1'b0; dly = 0; bcnt = 0; en_prev = 0; pend = '0; Req_valid = '0;
      end else begin
        if (bcnt > 0) begin bcnt--; if (bcnt == 0) Uart_TX_busy = 1'b0; end
        if (dly > 0) begin dly--; if (dly == 0) begin Uart_TX_busy = 1'b1; bcnt = busy_len; end end
        if (Uart_TX_EN && !en_prev) begin
          if (n_rise < 32) begin log_din[n_rise] = Uart_din; log_gnt[n_rise] = Grant; end
          if (n_rise > 0 && low_run < 2) gap_viol++;
          n_rise++;
          rise_cyc = cyc;
          if (!never_busy) dly = 1;
        end
        low_run = Uart_TX_EN ? 0 : low_run + 1;
        en_prev = Uart_TX_EN;
        if (Ack_err) begin n_err++; err_cyc = cyc; end
        for (int i = 0; i < 3; i++) begin
          if (pend[i]) rd[i]++;
          if (rd[i] != wr[i]) begin
            Req_valid[i]       = 1'b1;
            Req_data[i*8 +: 8] = mem[i][rd[i] % 16][7:0];
            Req_last[i]        = mem[i][rd[i] % 16][8];
          end else begin
            Req_valid[i] = 1'b0;
            Req_last[i]  = 1'b0;
          end
          pend[i] = Req_valid[i] & Req_ready[i];
        end
      end
    end
  end

  task automatic push(input int i, input logic [7:0] d, input logic l);
    mem[i][wr[i] % 16] = {l, d};
    wr[i]++;
  endtask

  task automatic flush_queues();
    for (int i = 0; i < 3; i++) rd[i] = wr[i];
  endtask

  task automatic clear_log();
    n_rise = 0; gap_viol = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_SYS);
    #2;
  endtask

  task automatic apply_reset();
    CLK_RST = 1'b0;
    flush_queues();
    tick(3);
    CLK_RST = 1'b1;
    tick(1);
  endtask

  function automatic bit q_empty();
    return (rd[0] == wr[0]) && (rd[1] == wr[1]) && (rd[2] == wr[2]);
  endfunction

  // Bounded wait for all queued frames to finish; counts cycles with a grant outside allow.
  task automatic wait_idle(input int budget, input logic [2:0] allow, output bit ok, output int foreign);
    ok = 0; foreign = 0;
    for (int c = 0; c < budget; c++) begin
      tick(1);
      if ((Grant & ~allow) != 3'b000) foreign++;
      if (q_empty() && !Sched_busy && !Uart_TX_EN && !Uart_TX_busy) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    CLK_RST = 1'b0;
    tick(2);
    total++; if (Grant !== 3'b000)     begin bad++; $display("FAIL rst_grant got=%b want=000", Grant); end
    total++; if (Req_ready !== 3'b000) begin bad++; $display("FAIL rst_ready got=%b want=000", Req_ready); end
    total++; if (Uart_TX_EN !== 1'b0)  begin bad++; $display("FAIL rst_en got=%b want=0", Uart_TX_EN); end
    total++; if (Uart_din !== 8'h00)   begin bad++; $display("FAIL rst_din got=%h want=00", Uart_din); end
    total++; if (Sched_busy !== 1'b0)  begin bad++; $display("FAIL rst_sbusy got=%b want=0", Sched_busy); end
    total++; if (Ack_err !== 1'b0)     begin bad++; $display("FAIL rst_err got=%b want=0", Ack_err); end
    CLK_RST = 1'b1;
    tick(1);
  endtask

  task automatic test_single_frame();
    bit ok; int foreign;
    clear_log();
    push(1, 8'h55, 1'b0);
    push(1, 8'hA3, 1'b1);
    wait_idle(200, 3'b010, ok, foreign);
    total++; if (!ok)             begin bad++; $display("FAIL single_done got=0 want=1"); end
    total++; if (n_rise != 2)     begin bad++; $display("FAIL single_count got=%0d want=2", n_rise); end
    total++; if (log_din[0] !== 8'h55) begin bad++; $display("FAIL single_din0 got=%h want=55", log_din[0]); end
    total++; if (log_din[1] !== 8'hA3) begin bad++; $display("FAIL single_din1 got=%h want=a3", log_din[1]); end
    total++; if (log_gnt[0] !== 3'b010 || log_gnt[1] !== 3'b010)
      begin bad++; $display("FAIL single_grant got=%b,%b want=010,010", log_gnt[0], log_gnt[1]); end
    total++; if (foreign != 0)    begin bad++; $display("FAIL single_foreign got=%0d want=0", foreign); end
    total++; if (Grant !== 3'b000) begin bad++; $display("FAIL single_release got=%b want=000", Grant); end
    total++; if (gap_viol != 0)   begin bad++; $display("FAIL single_en_gap got=%0d want=0", gap_viol); end
  endtask

  task automatic test_contention();
    bit ok; int foreign;
    logic [7:0] exp_d [3];
    logic [2:0] exp_g [3];
    apply_reset();
    clear_log();
    push(0, 8'h10, 1'b1); push(1, 8'h20, 1'b1); push(2, 8'h30, 1'b1);
    wait_idle(300, 3'b111, ok, foreign);
    exp_d = '{8'h10, 8'h20, 8'h30};
    exp_g = '{3'b001, 3'b010, 3'b100};
    total++; if (!ok || n_rise != 3) begin bad++; $display("FAIL cont_count got=%0d want=3", n_rise); end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (log_din[k] !== exp_d[k] || log_gnt[k] !== exp_g[k])
        begin bad++; $display("FAIL cont_order[%0d] got=%h/%b want=%h/%b", k, log_din[k], log_gnt[k], exp_d[k], exp_g[k]); end
    end
    clear_log();
    push(0, 8'h10, 1'b1); push(2, 8'h30, 1'b1);
    wait_idle(300, 3'b101, ok, foreign);
    total++; if (!ok || n_rise != 2) begin bad++; $display("FAIL wrap_count got=%0d want=2", n_rise); end
    total++; if (log_din[0] !== 8'h10 || log_din[1] !== 8'h30)
      begin bad++; $display("FAIL wrap_order got=%h,%h want=10,30", log_din[0], log_din[1]); end
  endtask

  task automatic test_frame_lock();
    bit ok; int foreign;
    logic [7:0] exp_d [4];
    logic [2:0] exp_g [4];
    clear_log();
    push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
    push(2, 8'h0F, 1'b1);
    wait_idle(400, 3'b101, ok, foreign);
    exp_d = '{8'h01, 8'h02, 8'h03, 8'h0F};
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b100};
    total++; if (!ok || n_rise != 4) begin bad++; $display("FAIL lock_count got=%0d want=4", n_rise); end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (log_din[k] !== exp_d[k] || log_gnt[k] !== exp_g[k])
        begin bad++; $display("FAIL lock_order[%0d] got=%h/%b want=%h/%b", k, log_din[k], log_gnt[k], exp_d[k], exp_g[k]); end
    end
    total++; if (gap_viol != 0) begin bad++; $display("FAIL lock_en_gap got=%0d want=0", gap_viol); end
  endtask

  task automatic test_stall();
    bit ok; int foreign; int stall_bad;
    clear_log();
    push(1, 8'hB1, 1'b0);
    push(2, 8'hC2, 1'b1);
    tick(20);
    total++; if (n_rise != 1 || log_din[0] !== 8'hB1)
      begin bad++; $display("FAIL stall_first got=%0d/%h want=1/b1", n_rise, log_din[0]); end
    stall_bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick(1);
      if (Grant !== 3'b010 || Uart_TX_EN !== 1'b0 || Sched_busy !== 1'b1) stall_bad++;
    end
    total++; if (stall_bad != 0) begin bad++; $display("FAIL stall_hold got=%0d want=0", stall_bad); end
    push(1, 8'hB2, 1'b1);
    wait_idle(200, 3'b110, ok, foreign);
    total++; if (!ok || n_rise != 3) begin bad++; $display("FAIL stall_resume got=%0d want=3", n_rise); end
    total++; if (log_din[1] !== 8'hB2 || log_din[2] !== 8'hC2 || log_gnt[2] !== 3'b100)
      begin bad++; $display("FAIL stall_after got=%h,%h/%b want=b2,c2/100", log_din[1], log_din[2], log_gnt[2]); end
  endtask

  task automatic test_timeout();
    bit seen; logic en_at, sb_at; logic [2:0] g_at; int e0;
    clear_log();
    never_busy = 1;
    e0 = n_err;
    seen = 0; en_at = 1'b1; sb_at = 1'b1; g_at = 3'b111;
    push(0, 8'h77, 1'b1);
    for (int c = 0; c < 60; c++) begin
      tick(1);
      if (Ack_err) begin seen = 1; en_at = Uart_TX_EN; g_at = Grant; sb_at = Sched_busy; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL to_seen got=0 want=1"); end
    total++; if (en_at !== 1'b0 || g_at !== 3'b000 || sb_at !== 1'b0)
      begin bad++; $display("FAIL to_abort got=en%b/g%b/sb%b want=en0/g000/sb0", en_at, g_at, sb_at); end
    tick(40);
    total++; if (n_err - e0 != 1) begin bad++; $display("FAIL to_pulses got=%0d want=1", n_err - e0); end
    total++; if (err_cyc - rise_cyc != 15) begin bad++; $display("FAIL to_latency got=%0d want=15", err_cyc - rise_cyc); end
    total++; if (Grant !== 3'b000 || Sched_busy !== 1'b0)
      begin bad++; $display("FAIL to_idle got=g%b/sb%b want=g000/sb0", Grant, Sched_busy); end
    never_busy = 0;
  endtask

  task automatic test_reset_mid();
    bit ok, reached; int foreign; int e0;
    clear_log();
    busy_len = 20;
    reached = 0;
    push(0, 8'h99, 1'b0); push(0, 8'h9A, 1'b1);
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (Uart_TX_busy && !Uart_TX_EN && Sched_busy) begin reached = 1; break; end
    end
    total++; if (!reached) begin bad++; $display("FAIL rmid_wait got=0 want=1"); end
    e0 = n_err;
    CLK_RST = 1'b0;
    flush_queues();
    #1;
    total++; if (Uart_TX_EN !== 1'b0 || Grant !== 3'b000 || Sched_busy !== 1'b0)
      begin bad++; $display("FAIL rmid_async got=en%b/g%b/sb%b want=en0/g000/sb0", Uart_TX_EN, Grant, Sched_busy); end
    total++; if (Req_ready !== 3'b000 || Uart_din !== 8'h00 || Ack_err !== 1'b0)
      begin bad++; $display("FAIL rmid_async2 got=rdy%b/din%h/err%b want=rdy000/din00/err0", Req_ready, Uart_din, Ack_err); end
    busy_len = 3;
    tick(3);
    CLK_RST = 1'b1;
    tick(5);
    total++; if (n_err != e0) begin bad++; $display("FAIL rmid_noerr got=%0d want=%0d", n_err, e0); end
    clear_log();
    push(1, 8'h61, 1'b1); push(0, 8'h60, 1'b1);
    wait_idle(300, 3'b011, ok, foreign);
    total++; if (!ok || n_rise != 2 || log_din[0] !== 8'h60 || log_din[1] !== 8'h61)
      begin bad++; $display("FAIL rmid_restart got=%0d:%h,%h want=2:60,61", n_rise, log_din[0], log_din[1]); end
  endtask

  initial begin
    CLK_RST = 1'b0;
    test_reset();
    test_single_frame();
    test_contention();
    test_frame_lock();
    test_stall();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
